pdm_cic_decimator: RTL and testbench

Third-order CIC (sinc³) decimator that converts a 1-bit PDM stream into signed PCM samples at 1/R of the PDM sample rate. It sits directly downstream of the second-order delta-sigma PDM modulator and recovers the PCM signal for loop-back checks and for the receive path. Output samples leave through a one-deep valid/ready buffer with a sticky overflow flag.

---
 rtl/pdm_cic_decimator.sv | 188 ++++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
//
// Third-order CIC (sinc^3) decimator. Turns a 1-bit PDM stream into signed
// W-bit PCM samples at 1/R of the PDM sample rate. Each decimated sample
// goes into a one-deep valid/ready output buffer. A sticky overflow flag
// records any sample that was dropped because the buffer was still full.
//
// Parameters
//   W  PCM output width in bits (default 16)
//   R  decimation ratio, power of two in 4..256, with 3*log2(R) >= W-1
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pdm_in     PDM bit (1 -> +1, 0 -> -1), sampled when pdm_valid is high
//   pdm_valid  PDM sample strobe
//   pcm_out    signed PCM sample, meaningful while pcm_valid is high
//   pcm_valid  output buffer holds a sample
//   pcm_ready  consumer accepts; transfer on pcm_valid && pcm_ready
//   ovf        sticky flag: a decimated sample was dropped
//   ovf_clr    synchronous clear of ovf
//
// Build option
//   PDM_CIC_SYNC_EN  when defined, pdm_in and pdm_valid pass through a
//                    two-flop synchronizer. All input-referred latencies
//                    then grow by two cycles.
// -----------------------------------------------------------------------------
module pdm_cic_decimator #(
  parameter int W = 16,
  parameter int R = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pdm_in,
  input  logic                pdm_valid,
  output logic signed [W-1:0] pcm_out,
  output logic                pcm_valid,
  input  logic                pcm_ready,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int L     = $clog2(R);
  localparam int B     = 3 * L + 2;
  localparam int SHIFT = 3 * L - (W - 1);

  localparam logic signed [B-1:0] Y_MAX = B'((2 ** (W - 1)) - 1);
  localparam logic signed [B-1:0] Y_MIN = -Y_MAX - B'(1);

  logic in_bit;
  logic in_vld;

`ifdef PDM_CIC_SYNC_EN
  logic [1:0] sync_bit;
  logic [1:0] sync_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_bit <= '0;
      sync_vld <= '0;
    end else begin
      sync_bit <= {sync_bit[0], pdm_in};
      sync_vld <= {sync_vld[0], pdm_valid};
    end
  end

  assign in_bit = sync_bit[1];
  assign in_vld = sync_vld[1];
`else
  assign in_bit = pdm_in;
  assign in_vld = pdm_valid;
`endif

  // Integrator section. All three stages update in the same cycle, and each
  // stage uses the freshly updated value of the stage before it. Wrap-around
  // modulo 2^B is intentional: the combs cancel it exactly.
  logic signed [B-1:0] x;
  logic signed [B-1:0] i1, i2, i3;
  logic signed [B-1:0] i1_n, i2_n, i3_n;
  logic [L-1:0]        ph;
  logic                strobe;

  assign x      = in_bit ? {{(B-1){1'b0}}, 1'b1} : {B{1'b1}};
  assign i1_n   = i1 + x;
  assign i2_n   = i2 + i1_n;
  assign i3_n   = i3 + i2_n;
  assign strobe = in_vld && (ph == {L{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      ph <= '0;
    end else if (in_vld) begin
      i1 <= i1_n;
      i2 <= i2_n;
      i3 <= i3_n;
      ph <= ph + L'(1);
    end
  end

  // Decimation register. s_pulse marks the single cycle in which s holds a
  // new sample and the comb section must run.
  logic signed [B-1:0] s;
  logic                s_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      s_pulse <= 1'b0;
    end else begin
      s_pulse <= strobe;
      if (strobe) begin
        s <= i3_n;
      end
    end
  end

  // Comb section at the decimated rate. The differences are combinational.
  // The delay registers advance only on s_pulse.
  logic signed [B-1:0] s_d, c1_d, c2_d;
  logic signed [B-1:0] c1, c2, c3;

  assign c1 = s - s_d;
  assign c2 = c1 - c1_d;
  assign c3 = c2 - c2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d  <= '0;
      c1_d <= '0;
      c2_d <= '0;
    end else if (s_pulse) begin
      s_d  <= s;
      c1_d <= c1;
      c2_d <= c2;
    end
  end

  // Scale the full-precision comb output down to W bits. A full-scale input
  // gives exactly +2^(W-1), which is the only value that needs clipping.
  // The lower clamp is kept for safety.
  logic signed [B-1:0] c3_sh;
  logic signed [W-1:0] y_sat;

  assign c3_sh = c3 >>> SHIFT;

  always_comb begin
    y_sat = c3_sh[W-1:0];
    if (c3_sh > Y_MAX) begin
      y_sat = Y_MAX[W-1:0];
    end else if (c3_sh < Y_MIN) begin
      y_sat = Y_MIN[W-1:0];
    end
  end

  // One-deep output buffer. A new sample may replace the held one only if
  // the buffer is empty or is being emptied in this same cycle. Otherwise
  // the new sample is dropped and ovf is set. A new overflow wins over
  // ovf_clr when both happen in the same cycle.
  logic drop;

  assign drop = s_pulse && pcm_valid && !pcm_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s_pulse && (!pcm_valid || pcm_ready)) begin
        pcm_out   <= y_sat;
        pcm_valid <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_pdm_cic_decimator
//
// Bench for pdm_cic_decimator (W=16, R=64).
//
// The reference model treats the decimator as a sinc^3 FIR filter:
// h = box(R) * box(R) * box(R). This filter is applied to the +/-1 sample
// history at every R-th accepted PDM sample. A simple timing model then
// delivers each result into a one-deep buffer.
//
// Inputs change 1 time unit after each rising edge. Outputs are checked on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_pdm_cic_decimator;

  localparam int W     = 16;
  localparam int R     = 64;
  localparam int L     = 6;
  localparam int SHIFT = 3 * L - (W - 1);
  localparam int HLEN  = 3 * R - 2;
`ifdef PDM_CIC_SYNC_EN
  localparam int LAT   = R + 3;
`else
  localparam int LAT   = R + 1;
`endif

  logic                clk;
  logic                rst_n;
  logic                pdm_in;
  logic                pdm_valid;
  logic signed [W-1:0] pcm_out;
  logic                pcm_valid;
  logic                pcm_ready;
  logic                ovf;
  logic                ovf_clr;

  pdm_cic_decimator #(.W(W), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pdm_in    (pdm_in),
    .pdm_valid (pdm_valid),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int h2[2*R-1];
  int h[HLEN];
  int hist[$];
  int got[$];
  int m_ph;
  bit m_valid;
  int m_out;
  bit m_ovf;
  bit m_pend;
  int m_pend_val;
  bit m_set_ovf;
  bit eff_v, eff_b;
  bit d1v, d2v, d1b, d2b;

  task automatic check_output(input string name, input logic signed [63:0] actual,
                              input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input bit v, input bit b, input bit rdy, input bit clr);
    pdm_valid = v;
    pdm_in    = b;
    pcm_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pdm_valid = 1'b0;
    pdm_in    = 1'b0;
    pcm_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
  endtask

  // sinc^3 output for the current sample history, scaled and clipped to W bits
  function automatic int model_sample();
    int acc;
    int n;
    int v;
    acc = 0;
    n   = hist.size();
    for (int j = 0; j < n; j++) acc += h[j] * hist[n-1-j];
    v = acc >>> SHIFT;
    if (v > (2 ** (W - 1)) - 1) v = (2 ** (W - 1)) - 1;
    if (v < -(2 ** (W - 1))) v = -(2 ** (W - 1));
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("rst_pcm_valid", pcm_valid, 0);
      check_output("rst_pcm_out", $signed(pcm_out), 0);
      check_output("rst_ovf", ovf, 0);
      hist.delete();
      m_ph = 0; m_valid = 0; m_out = 0; m_ovf = 0; m_pend = 0; m_pend_val = 0;
      d1v = 0; d2v = 0; d1b = 0; d2b = 0;
    end else begin
      check_output("pcm_valid", pcm_valid, m_valid);
      check_output("ovf", ovf, m_ovf);
      if (m_valid) check_output("pcm_out", $signed(pcm_out), m_out);
      if (pcm_valid && pcm_ready) got.push_back(int'($signed(pcm_out)));

`ifdef PDM_CIC_SYNC_EN
      eff_v = d2v; eff_b = d2b;
      d2v = d1v;   d2b = d1b;
      d1v = pdm_valid; d1b = pdm_in;
`else
      eff_v = pdm_valid; eff_b = pdm_in;
`endif

      m_set_ovf = 0;
      if (m_pend) begin
        if (!m_valid || pcm_ready) begin
          m_out   = m_pend_val;
          m_valid = 1;
        end else begin
          m_set_ovf = 1;
        end
      end else if (m_valid && pcm_ready) begin
        m_valid = 0;
      end
      if (m_set_ovf) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;

      m_pend = 0;
      if (eff_v) begin
        hist.push_back(eff_b ? 1 : -1);
        if (hist.size() > HLEN) void'(hist.pop_front());
        if (m_ph == R - 1) begin
          m_ph       = 0;
          m_pend     = 1;
          m_pend_val = model_sample();
        end else begin
          m_ph++;
        end
      end
    end
  end

  task automatic run_pattern(input string nm, input bit [3:0] pat, input int plen, input int expv);
    do_reset();
    for (int i = 0; i < 8 * R + 6; i++) apply_stimulus(1'b1, pat[i % plen], 1'b1, 1'b0);
    check_output({nm, "_count_ok"}, (got.size() >= 8) ? 1 : 0, 1);
    if (got.size() >= 8) begin
      for (int k = 3; k < 8; k++) check_output($sformatf("%s_out%0d", nm, k + 1), got[k], expv);
    end
  endtask

  initial begin
    int rises[$];
    int first;
    int n0;

    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) h2[i+j] += 1;
    for (int k = 0; k < 2 * R - 1; k++)
      for (int j = 0; j < R; j++) h[k+j] += h2[k];

    pdm_valid = 0; pdm_in = 0; pcm_ready = 0; ovf_clr = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_output("init_pcm_valid", pcm_valid, 0);
    check_output("init_pcm_out", $signed(pcm_out), 0);
    check_output("init_ovf", ovf, 0);

    // Constant and periodic inputs with known steady-state outputs
    run_pattern("ones", 4'b0001, 1, 32767);
    if (got.size() >= 2) begin
      check_output("ones_out1", got[0], 5720);
      check_output("ones_out2", got[1], 27560);
    end
    run_pattern("zeros", 4'b0000, 1, -32768);
    check_output("zeros_ovf", ovf, 0);
    run_pattern("alt10", 4'b0001, 2, 0);
    run_pattern("p1110", 4'b0111, 4, 16384);

    // Back-pressure: the first sample is held and later samples are dropped
    do_reset();
    for (int i = 0; i < 3 * R + 10; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("hold_valid", pcm_valid, 1);
    check_output("hold_out", $signed(pcm_out), 5720);
    check_output("hold_ovf", ovf, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("ovf_cleared", ovf, 0);
    n0 = got.size();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("held_xfer_count", got.size(), n0 + 1);
    if (got.size() == n0 + 1) check_output("held_xfer_value", got[n0], 5720);
    check_output("after_xfer_valid", pcm_valid, 0);

    // Output pulse timing with pdm_valid on every cycle
    do_reset();
    rises.delete();
    for (int i = 1; i <= 4 * R + 10; i++) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (pcm_valid) rises.push_back(i);
    end
    check_output("pulse_count_ok", (rises.size() >= 3) ? 1 : 0, 1);
    if (rises.size() >= 3) begin
      check_output("first_pulse", rises[0], LAT);
      check_output("pulse_gap1", rises[1] - rises[0], R);
      check_output("pulse_gap2", rises[2] - rises[1], R);
    end

    // Reset mid-operation while a sample is held
    do_reset();
    for (int i = 0; i < R + 30; i++) apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check_output("pre_rst_valid", pcm_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_valid", pcm_valid, 0);
    check_output("midrst_out", $signed(pcm_out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 3 * R; i++) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (pcm_valid) begin
        first = i;
        break;
      end
    end
    check_output("post_rst_first_pulse", first, LAT);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++)
      apply_stimulus(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
